// File: rtl/bcd_scan_ctrl_if.sv
// Bundle of the converter handshake, result digits and display scan outputs.
interface bcd_scan_ctrl_if;
   logic       start;
   logic [7:0] binary;
   logic       busy;
   logic       done;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [2:0] an;
   logic [3:0] digit;

   // Requester side: issues conversions and watches results/display.
   modport master (
      output start, binary,
      input  busy, done, hundreds, tens, ones, an, digit
   );

   // Converter side.
   modport slave (
      input  start, binary,
      output busy, done, hundreds, tens, ones, an, digit
   );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// 8-bit binary to 3-digit BCD converter (shift-and-add-3, one bit per clock)
// feeding a free-running, multiplexed 3-digit display scanner.
module bcd_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,  // clk cycles per active digit, >= 2
   parameter bit BLANK_LZ    = 1'b1    // 1: blank leading zeros
) (
   input  logic           clk,
   input  logic           reset,
   bcd_scan_ctrl_if.slave bus
);

   localparam int                 CNT_W    = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t      state_q, state_d;
   logic        busy, load, last_shift;
   logic [7:0]  shift_q;
   logic [11:0] bcd_q, bcd_adj, bcd_nxt;
   logic [7:0]  shift_nxt;
   logic [3:0]  bit_cnt_q;
   logic        done_q;
   logic [3:0]  hund_q, tens_q, ones_q;

   logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
   logic [1:0]       scan_idx_q, scan_idx_d;
   logic [2:0]       an_q, an_d;
   logic [3:0]       digit_q, digit_d;

   // ------------------------------------------------------------------
   // Converter FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state: a start in IDLE begins a pass; the last shift returns to IDLE.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start)         state_d = S_SHIFT;
         S_SHIFT: if (bit_cnt_q == 4'd0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: busy flag, load strobe and final-shift strobe.
   always_comb begin
      busy       = (state_q == S_SHIFT);
      load       = (state_q == S_IDLE) && bus.start;
      last_shift = (state_q == S_SHIFT) && (bit_cnt_q == 4'd0);
   end

   // ------------------------------------------------------------------
   // Double-dabble datapath
   // ------------------------------------------------------------------

   // Add 3 to each working nibble >= 5, then shift {bcd, binary} left one bit.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      {bcd_nxt, shift_nxt} = {bcd_adj, shift_q} << 1;
   end

   // Working registers, bit counter, result digits and done pulse.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         shift_q   <= '0;
         bcd_q     <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
         hund_q    <= '0;
         tens_q    <= '0;
         ones_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            shift_q   <= bus.binary;
            bcd_q     <= '0;
            bit_cnt_q <= 4'd7;
         end else if (busy) begin
            shift_q <= shift_nxt;
            bcd_q   <= bcd_nxt;
            if (bit_cnt_q != 4'd0) bit_cnt_q <= bit_cnt_q - 4'd1;
            if (last_shift) begin
               hund_q <= bcd_nxt[11:8];
               tens_q <= bcd_nxt[7:4];
               ones_q <= bcd_nxt[3:0];
               done_q <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Display scan (independent of the converter)
   // ------------------------------------------------------------------

   // Refresh divider and scan index advance (0 -> 1 -> 2 -> 0).
   always_comb begin
      refresh_cnt_d = refresh_cnt_q + 1'b1;
      scan_idx_d    = scan_idx_q;
      if (refresh_cnt_q == CNT_LAST) begin
         refresh_cnt_d = '0;
         scan_idx_d    = (scan_idx_q == 2'd2) ? 2'd0 : scan_idx_q + 2'd1;
      end
   end

   // Digit enable and code for the current index, with leading-zero blanking.
   always_comb begin
      an_d    = 3'b110;
      digit_d = ones_q;
      case (scan_idx_q)
         2'd1: begin
            an_d    = (BLANK_LZ && hund_q == 4'd0 && tens_q == 4'd0) ? 3'b111 : 3'b101;
            digit_d = tens_q;
         end
         2'd2: begin
            an_d    = (BLANK_LZ && hund_q == 4'd0) ? 3'b111 : 3'b011;
            digit_d = hund_q;
         end
         default: begin
            an_d    = 3'b110;
            digit_d = ones_q;
         end
      endcase
   end

   // Scan registers; an/digit trail the index and results by one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt_q <= '0;
         scan_idx_q    <= 2'd0;
         an_q          <= 3'b110;
         digit_q       <= 4'd0;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
         scan_idx_q    <= scan_idx_d;
         an_q          <= an_d;
         digit_q       <= digit_d;
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.hundreds = hund_q;
   assign bus.tens     = tens_q;
   assign bus.ones     = ones_q;
   assign bus.an       = an_q;
   assign bus.digit    = digit_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: table vectors, directed corner
// sequences and random stimulus against a cycle-level reference model.
module tb_bcd_scan_ctrl;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bcd_scan_ctrl_if bus_a ();
   bcd_scan_ctrl_if bus_b ();

   bcd_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   bcd_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_done = 0;

   // Reference model state.
   bit         m_busy, m_done;
   int         m_left, m_val, m_h, m_t, m_o, m_k;
   logic [2:0] m_an_a, m_an_b;
   int         m_dig_a, m_dig_b;

   typedef struct {
      logic [7:0] bin;
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
   } vec_t;

   vec_t       vecs[8];
   logic [2:0] pat_a_an[3];
   logic [3:0] pat_a_dig[3];
   logic [2:0] pat_b_an[3];

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_an(input int idx, input int h, input int t, input bit blank);
      if (idx == 0)      return 3'b110;
      else if (idx == 1) return (blank && h == 0 && t == 0) ? 3'b111 : 3'b101;
      else               return (blank && h == 0) ? 3'b111 : 3'b011;
   endfunction

   // One clock: advance the model with the inputs present at the edge,
   // then compare every output of both instances shortly after the edge.
   task automatic tick();
      bit rst_s, st_s;
      int bin_s, idx;
      rst_s = reset;
      st_s  = bus_a.start;
      bin_s = bus_a.binary;
      @(posedge clk);
      cyc++;
      if (rst_s) begin
         m_busy = 0; m_done = 0; m_left = 0;
         m_h = 0; m_t = 0; m_o = 0; m_k = 0;
         m_an_a = 3'b110; m_dig_a = 0;
         m_an_b = 3'b110; m_dig_b = 0;
      end else begin
         idx     = (m_k / DIV) % 3;
         m_an_a  = ref_an(idx, m_h, m_t, 1'b1);
         m_dig_a = (idx == 0) ? m_o : (idx == 1) ? m_t : m_h;
         m_an_b  = ref_an(idx, 0, 0, 1'b0);
         m_dig_b = 0;
         m_k++;
         if (!m_busy) begin
            m_done = 0;
            if (st_s) begin
               m_busy = 1; m_left = 8; m_val = bin_s;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1;
               m_h = m_val / 100; m_t = (m_val / 10) % 10; m_o = m_val % 10;
            end
         end
      end
      #1;
      if (bus_a.done === 1'b1) n_done++;
      check("a_busy",  12'(bus_a.busy),     12'(m_busy));
      check("a_done",  12'(bus_a.done),     12'(m_done));
      check("a_hund",  12'(bus_a.hundreds), 12'(m_h));
      check("a_tens",  12'(bus_a.tens),     12'(m_t));
      check("a_ones",  12'(bus_a.ones),     12'(m_o));
      check("a_an",    12'(bus_a.an),       12'(m_an_a));
      check("a_digit", 12'(bus_a.digit),    12'(m_dig_a));
      check("b_an",    12'(bus_b.an),       12'(m_an_b));
      check("b_digit", 12'(bus_b.digit),    12'(m_dig_b));
      check("b_idle",  12'({bus_b.busy, bus_b.done}), 12'd0);
   endtask

   // Launch one conversion and wait (bounded) for its done pulse.
   task automatic run_conv(input logic [7:0] val, output bit got);
      got = 0;
      bus_a.start  = 1'b1;
      bus_a.binary = val;
      tick();
      bus_a.start  = 1'b0;
      bus_a.binary = 8'($urandom);
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         if (bus_a.done === 1'b1) got = 1;
      end
      check("conv_done_seen", 12'(got), 12'd1);
   endtask

   // Wait (bounded) for the scan to enter the ones digit on the given bus.
   task automatic sync_scan(input bit use_b, output bit found);
      logic [2:0] prev, cur;
      found = 0;
      prev  = use_b ? bus_b.an : bus_a.an;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         cur = use_b ? bus_b.an : bus_a.an;
         if (cur == 3'b110 && prev != 3'b110) found = 1;
         prev = cur;
      end
      check(use_b ? "scan_b_sync" : "scan_a_sync", 12'(found), 12'd1);
   endtask

   initial begin
      bit got, found;
      int last_cyc, d0;

      vecs[0] = '{8'd0,   4'd0, 4'd0, 4'd0};
      vecs[1] = '{8'd9,   4'd0, 4'd0, 4'd9};
      vecs[2] = '{8'd10,  4'd0, 4'd1, 4'd0};
      vecs[3] = '{8'd99,  4'd0, 4'd9, 4'd9};
      vecs[4] = '{8'd100, 4'd1, 4'd0, 4'd0};
      vecs[5] = '{8'd199, 4'd1, 4'd9, 4'd9};
      vecs[6] = '{8'd200, 4'd2, 4'd0, 4'd0};
      vecs[7] = '{8'd255, 4'd2, 4'd5, 4'd5};
      pat_a_an[0] = 3'b110; pat_a_an[1] = 3'b101; pat_a_an[2] = 3'b111;
      pat_a_dig[0] = 4'd2;  pat_a_dig[1] = 4'd4;  pat_a_dig[2] = 4'd0;
      pat_b_an[0] = 3'b110; pat_b_an[1] = 3'b101; pat_b_an[2] = 3'b011;

      reset = 1'b1;
      bus_a.start = 1'b0; bus_a.binary = 8'd0;
      bus_b.start = 1'b0; bus_b.binary = 8'd0;
      tick();
      tick();
      check("rst_an",    12'(bus_a.an),    12'h6);
      check("rst_digit", 12'(bus_a.digit), 12'h0);
      reset = 1'b0;
      tick();

      // Full-scale conversion: busy through E8, done after E8, 2/5/5.
      bus_a.start = 1'b1; bus_a.binary = 8'd255;
      tick();
      check("e0_busy", 12'(bus_a.busy), 12'd1);
      bus_a.start = 1'b0; bus_a.binary = 8'd0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i < 8) check("e_busy", 12'(bus_a.busy), 12'd1);
      end
      check("e8_done", 12'(bus_a.done), 12'd1);
      check("e8_busy", 12'(bus_a.busy), 12'd0);
      check("e8_res",  12'({bus_a.hundreds, bus_a.tens, bus_a.ones}), 12'h255);
      tick();
      check("e9_done", 12'(bus_a.done), 12'd0);

      // Table of conversions.
      for (int i = 0; i < 8; i++) begin
         run_conv(vecs[i].bin, got);
         check("tbl_hund", 12'(bus_a.hundreds), 12'(vecs[i].h));
         check("tbl_tens", 12'(bus_a.tens),     12'(vecs[i].t));
         check("tbl_ones", 12'(bus_a.ones),     12'(vecs[i].o));
         tick();
      end

      // Back-to-back sweep with start held high.
      bus_a.start = 1'b1;
      last_cyc = 0;
      for (int v = 0; v < 256; v++) begin
         bus_a.binary = 8'(v);
         tick();
         bus_a.binary = 8'($urandom);
         repeat (8) tick();
         check("sw_done", 12'(bus_a.done), 12'd1);
         check("sw_res", 12'({bus_a.hundreds, bus_a.tens, bus_a.ones}),
               12'({4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}));
         if (v > 0) check("sw_spacing", 12'(cyc - last_cyc), 12'd9);
         last_cyc = cyc;
      end
      bus_a.start = 1'b0;
      tick();

      // Start during SHIFT is ignored.
      d0 = n_done;
      bus_a.start = 1'b1; bus_a.binary = 8'd7;
      tick();
      bus_a.start = 1'b0; bus_a.binary = 8'd0;
      tick(); tick();
      bus_a.start = 1'b1; bus_a.binary = 8'd200;
      tick();
      bus_a.start = 1'b0;
      repeat (5) tick();
      check("ign_res", 12'({bus_a.hundreds, bus_a.tens, bus_a.ones}), 12'h007);
      repeat (8) tick();
      check("ign_pulses", 12'(n_done - d0), 12'd1);

      // Reset aborts a conversion.
      d0 = n_done;
      bus_a.start = 1'b1; bus_a.binary = 8'd128;
      tick();
      bus_a.start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 12'(bus_a.busy), 12'd0);
      check("abort_res",  12'({bus_a.hundreds, bus_a.tens, bus_a.ones}), 12'h000);
      check("abort_an",   12'(bus_a.an), 12'h6);
      repeat (10) tick();
      check("abort_nodone", 12'(n_done - d0), 12'd0);

      // Scan pattern with blanking, result 0/4/2.
      run_conv(8'd42, got);
      sync_scan(1'b0, found);
      if (found) begin
         for (int p = 0; p < 24; p++) begin
            if (p > 0) tick();
            check("scan_a_an",  12'(bus_a.an),    12'(pat_a_an[(p / DIV) % 3]));
            check("scan_a_dig", 12'(bus_a.digit), 12'(pat_a_dig[(p / DIV) % 3]));
         end
      end

      // Scan pattern without blanking, result 0/0/0.
      sync_scan(1'b1, found);
      if (found) begin
         for (int p = 0; p < 24; p++) begin
            if (p > 0) tick();
            check("scan_b_an",  12'(bus_b.an),    12'(pat_b_an[(p / DIV) % 3]));
            check("scan_b_dig", 12'(bus_b.digit), 12'd0);
         end
      end

      // Random start/binary/reset traffic against the model.
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 59) == 0);
         bus_a.start  = ($urandom_range(0, 3) == 0);
         bus_a.binary = 8'($urandom);
         tick();
      end
      reset = 1'b0;
      bus_a.start = 1'b0;
      repeat (12) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_scan_ctrl.md
BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, sets the number of clk cycles each display digit stays active (minimum 2).
REQ-002 Parameter BLANK_LZ, default 1, enables leading-zero blanking when 1.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request to convert binary; sampled only in IDLE.
REQ-006 Port binary  input  8  unsigned value to convert; captured on start acceptance.
REQ-007 Port busy  output  1  high while a conversion is in progress.
REQ-008 Port done  output  1  one-cycle pulse marking new result valid.
REQ-009 Port hundreds  output  4  registered BCD hundreds digit of last completed conversion.
REQ-010 Port tens  output  4  registered BCD tens digit.
REQ-011 Port ones  output  4  registered BCD ones digit.
REQ-012 Port an  output  3  active-low digit enable; bit0 ones, bit1 tens, bit2 hundreds.
REQ-013 Port digit  output  4  BCD code of the currently enabled digit.

Function
REQ-014 Converter FSM states IDLE and SHIFT only; a 4-bit bit counter tracks SHIFT progress.
REQ-015 In IDLE, start=1 at an edge captures binary into an 8-bit shift register, clears the 12-bit BCD working register, loads bit counter with 7, enters SHIFT, and sets busy=1.
REQ-016 In SHIFT, each edge applies add-3 to every working nibble >=5, then shifts the whole {working, shift} register left one bit, MSB of binary first.
REQ-017 SHIFT lasts exactly 8 edges; the 8th edge loads hundreds/tens/ones from the final working value, sets done=1, clears busy, returns to IDLE.
REQ-018 Latency: start accepted at edge E0; results and done visible after edge E8; done deasserts after E9 unless a new conversion completes there.
REQ-019 start while busy=1 is ignored; binary changes during SHIFT have no effect on the result.
REQ-020 start=1 in the cycle where done=1 (FSM in IDLE) is accepted; back-to-back conversions therefore take 9 cycles each.
REQ-021 hundreds/tens/ones hold their previous value throughout a conversion; they change only at the REQ-017 edge.
REQ-022 Results for all inputs 0..255 match decimal digits; hundreds never exceeds 2.
REQ-023 Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0; on each wrap the scan index advances 0->1->2->0; index value 3 never occurs.
REQ-024 an is one-hot-low for the scan index (0: 3'b110, 1: 3'b101, 2: 3'b011); digit equals ones/tens/hundreds for index 0/1/2.
REQ-025 With BLANK_LZ=1: index 2 with hundreds=0 drives an=3'b111; index 1 with hundreds=0 and tens=0 drives an=3'b111; ones is never blanked; digit value is unaffected.
REQ-026 Scan logic runs independently of converter FSM state; a conversion never stalls or resets the scan.
REQ-027 an and digit are registered outputs, updated one edge after the scan index or result changes.

Reset
REQ-028 reset=1 at an edge forces: FSM IDLE, busy=0, done=0, hundreds=tens=ones=0, bit counter 0, refresh counter 0, scan index 0, an=3'b110, digit=0.
REQ-029 reset takes priority over start and over an in-progress SHIFT; an aborted conversion produces no done pulse and leaves results at 0.
REQ-030 After reset deassertion, the first start is accepted on the next edge with start=1.

Verification
REQ-031 reset, start=1 binary=255 for one cycle -> busy high E0..E8, done pulse after E8, hundreds=2 tens=5 ones=5.
REQ-032 Sweep binary 0..255 back-to-back with start held high -> every done pulse 9 cycles apart, digits match decimal value.
REQ-033 binary=7, start pulsed again at E3 with binary=200 -> second start ignored, result 0/0/7, single done pulse.
REQ-034 Start binary=128, assert reset at E4 -> no done, busy=0 next cycle, results 0/0/0, an=3'b110.
REQ-035 REFRESH_DIV=4, BLANK_LZ=1, result 0/4/2 -> an sequence 110 (digit 2), 101 (digit 4), 111 (digit 0), each held 4 cycles, then repeats.
REQ-036 REFRESH_DIV=4, BLANK_LZ=0, result 0/0/0 -> an cycles 110, 101, 011 with digit=0 throughout.
